// File: rtl/bus_pkg.sv
// Shared bus widths and responder state type.
// Imported by the RAM responder and its storage array.
package bus_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_BE_W   = 4;

    typedef enum logic [0:0] {
        ST_INIT   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/bus_ram_array.sv
// Single-port word RAM with byte write enables.
// Read data is registered: it appears the cycle after the address.
module bus_ram_array
    import bus_pkg::*;
#(
    parameter int ADDR_BITS = 12
) (
    input  logic                  clk,
    input  logic [ADDR_BITS-1:0]  addr,
    input  logic                  we,
    input  logic [BUS_BE_W-1:0]   be,
    input  logic [BUS_DATA_W-1:0] wdata,
    output logic [BUS_DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [BUS_DATA_W-1:0] mem [DEPTH];

    // Byte-masked write and read-first synchronous read on the one port.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BUS_BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/bus_ram_responder.sv
// Bus slave backed by a zero-initialised RAM.
// Fixed-latency pipelined reads, byte-masked writes, sticky error.
module bus_ram_responder
    import bus_pkg::*;
#(
    parameter int                    ADDR_BITS    = 12,
    parameter logic [BUS_ADDR_W-1:0] BASE_ADDR    = 32'h1000_0000,
    parameter int                    READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic                  ready,
    input  logic [BUS_ADDR_W-1:0] addr,
    input  logic [BUS_DATA_W-1:0] write_data,
    input  logic [BUS_BE_W-1:0]   byte_enable,
    input  logic                  write_req,
    input  logic                  read_req,
    output logic [BUS_DATA_W-1:0] read_data,
    output logic                  read_data_valid,
    output logic                  error
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [BUS_ADDR_W-1:0] SPAN = BUS_ADDR_W'(DEPTH) << 2;
    localparam logic [ADDR_BITS:0] LAST = (ADDR_BITS+1)'(DEPTH - 1);

    state_t                  state;
    logic [ADDR_BITS:0]      init_cnt;
    logic [BUS_ADDR_W-1:0]   offset;
    logic                    in_range;
    logic [ADDR_BITS-1:0]    word_idx;
    logic                    acc_wr;
    logic                    acc_rd;
    logic                    acc_both;
    logic                    ram_we;
    logic [ADDR_BITS-1:0]    ram_addr;
    logic [BUS_BE_W-1:0]     ram_be;
    logic [BUS_DATA_W-1:0]   ram_wdata;
    logic [BUS_DATA_W-1:0]   ram_rdata;
    logic [READ_LATENCY-1:0] rd_vld;
    logic                    rd_oor;
    logic [BUS_DATA_W-1:0]   head;

    assign ready    = (state == ST_ACTIVE);
    assign offset   = addr - BASE_ADDR;
    assign in_range = (addr >= BASE_ADDR) && (offset < SPAN);
    assign word_idx = offset[ADDR_BITS+1:2];

    // A read paired with a write is dropped; the write still happens.
    assign acc_wr   = ready && write_req;
    assign acc_rd   = ready && read_req && !write_req;
    assign acc_both = ready && write_req && read_req;

    // Port mux: INIT owns the RAM and clears it, then the bus takes over.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = word_idx;
        ram_be    = byte_enable;
        ram_wdata = write_data;
        if (state == ST_INIT) begin
            ram_we    = 1'b1;
            ram_addr  = init_cnt[ADDR_BITS-1:0];
            ram_be    = '1;
            ram_wdata = '0;
        end else begin
            ram_we = acc_wr && in_range;
        end
    end

    bus_ram_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_array (
        .clk  (clk),
        .addr (ram_addr),
        .we   (ram_we),
        .be   (ram_be),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    // Clear sequencer: one word per cycle, then switch to ACTIVE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == LAST) begin
                state <= ST_ACTIVE;
            end
        end
    end

    // Sticky flag for decode misses and read/write collisions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            error <= 1'b0;
        end else if (((acc_wr || acc_rd) && !in_range) || acc_both) begin
            error <= 1'b1;
        end
    end

    // Valid shift chain; stage 0 lines up with the array's read output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_vld <= '0;
            rd_oor <= 1'b0;
        end else begin
            rd_vld[0] <= acc_rd;
            rd_oor    <= acc_rd && !in_range;
            for (int k = 1; k < READ_LATENCY; k++) begin
                rd_vld[k] <= rd_vld[k-1];
            end
        end
    end

    assign head = (rd_vld[0] && !rd_oor) ? ram_rdata : '0;
    assign read_data_valid = rd_vld[READ_LATENCY-1];

    if (READ_LATENCY == 1) begin : g_direct
        assign read_data = head;
    end else begin : g_pipe
        logic [BUS_DATA_W-1:0] dq [READ_LATENCY-1];

        // Extra data stages to stretch the array read to the full latency.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int k = 0; k < READ_LATENCY - 1; k++) begin
                    dq[k] <= '0;
                end
            end else begin
                dq[0] <= head;
                for (int k = 1; k < READ_LATENCY - 1; k++) begin
                    dq[k] <= dq[k-1];
                end
            end
        end

        assign read_data = rd_vld[READ_LATENCY-1] ? dq[READ_LATENCY-2] : '0;
    end

endmodule

// File: tb/tb_bus_ram_responder.sv
// Directed bench for bus_ram_responder (ADDR_BITS=4, READ_LATENCY=2).
// Vector table for single transactions plus hand-written sequences.
module tb_bus_ram_responder;

    localparam logic [31:0] BASE = 32'h1000_0000;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        exp_vld;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [3:0]  byte_enable;
    logic        write_req;
    logic        read_req;
    logic [31:0] read_data;
    logic        read_data_valid;
    logic        error;

    int checks = 0;
    int errors = 0;

    vec_t vecs [12];

    bus_ram_responder #(
        .ADDR_BITS   (4),
        .BASE_ADDR   (BASE),
        .READ_LATENCY(2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ready          (ready),
        .addr           (addr),
        .write_data     (write_data),
        .byte_enable    (byte_enable),
        .write_req      (write_req),
        .read_req       (read_req),
        .read_data      (read_data),
        .read_data_valid(read_data_valid),
        .error          (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        write_req   = wr;
        read_req    = rd;
        addr        = a;
        write_data  = d;
        byte_enable = be;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Assert reset asynchronously, check outputs at once, release after a posedge.
    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        idle();
        #1;
        check({tag, "_rst_ready"}, ready, 0);
        check({tag, "_rst_vld"}, read_data_valid, 0);
        check({tag, "_rst_data"}, read_data, 0);
        check({tag, "_rst_err"}, error, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Count sampled cycles with ready low; optionally poke requests meanwhile.
    task automatic wait_init(input bit poke, output int n, output int vseen);
        bit done;
        n = 0;
        vseen = 0;
        done = 1'b0;
        while (!done && n < 100) begin
            @(negedge clk);
            if (read_data_valid) vseen++;
            if (ready) begin
                done = 1'b1;
            end else begin
                n++;
                if (poke && n < 4)
                    drive(1'b1, 1'b0, BASE, 32'h77, 4'hF);
                else if (poke && n < 8)
                    drive(1'b1, 1'b1, 32'h2000_0000, 32'h99, 4'hF);
                else
                    idle();
            end
        end
        idle();
    endtask

    // One transaction: issue, then check the cycles around the return slot.
    task automatic run_vec(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        drive(v.wr, v.rd, v.addr, v.wdata, v.be);
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        check({tag, "_early_vld"}, read_data_valid, 0);
        @(negedge clk);
        check({tag, "_vld"}, read_data_valid, v.exp_vld);
        check({tag, "_data"}, read_data, v.exp_vld ? v.exp_data : 32'h0);
        @(negedge clk);
        check({tag, "_late_vld"}, read_data_valid, 0);
        check({tag, "_err"}, error, v.exp_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   n;
        int   vs;
        vec_t v;

        vecs[0]  = '{1'b0, 1'b1, 32'h1000_0000, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h1000_0008, 32'hAABB_CCDD, 4'hF, 1'b0, 32'h0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h1000_000A, 32'h1122_3344, 4'hC, 1'b0, 32'h0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h1000_0008, 32'h0, 4'h0, 1'b1, 32'h1122_CCDD, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'h1000_000B, 32'h0, 4'h0, 1'b1, 32'h1122_CCDD, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h1000_003C, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'h1000_003F, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h1000_0004, 32'h1234_56A5, 4'h1, 1'b0, 32'h0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h1000_0004, 32'h0, 4'h0, 1'b1, 32'h0000_00A5, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h1000_0040, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 32'h1000_0000, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 32'h0FFF_FFFC, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1};

        reset_n = 1'b1;
        idle();
        #3;
        do_reset("boot");
        wait_init(1'b1, n, vs);
        check("boot_init_len", n, 16);
        check("boot_init_vld", vs, 0);
        check("boot_init_err", error, 0);

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        for (int j = 0; j < 11; j++) begin
            logic        ev;
            logic [31:0] ed;
            @(posedge clk);
            #1;
            if (j < 4)
                drive(1'b1, 1'b0, BASE + 32'(4 * j), 32'(j), 4'hF);
            else if (j < 8)
                drive(1'b0, 1'b1, BASE + 32'(4 * (j - 4)), 32'h0, 4'h0);
            else
                idle();
            @(negedge clk);
            ev = (j >= 6 && j <= 9);
            ed = ev ? 32'(j - 6) : 32'h0;
            check($sformatf("b2b%0d_ready", j), ready, 1);
            check($sformatf("b2b%0d_vld", j), read_data_valid, ev);
            check($sformatf("b2b%0d_data", j), read_data, ed);
        end

        for (int j = 0; j < 5; j++) begin
            @(posedge clk);
            #1;
            if (j == 0)
                drive(1'b1, 1'b0, 32'h1000_0014, 32'h5A5A_5A5A, 4'hF);
            else if (j == 1)
                drive(1'b0, 1'b1, 32'h1000_0014, 32'h0, 4'h0);
            else
                idle();
            @(negedge clk);
            check($sformatf("raw%0d_vld", j), read_data_valid, j == 3);
            check($sformatf("raw%0d_data", j), read_data,
                  (j == 3) ? 32'h5A5A_5A5A : 32'h0);
        end

        do_reset("oor");
        wait_init(1'b0, n, vs);
        check("oor_init_len", n, 16);
        check("oor_pre_err", error, 0);
        v = '{1'b0, 1'b1, 32'h2000_0000, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1};
        run_vec(v, "oor_rd");
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("oor_sticky", error, 1);

        do_reset("both");
        wait_init(1'b0, n, vs);
        check("both_init_len", n, 16);
        v = '{1'b1, 1'b1, 32'h1000_0004, 32'h55, 4'hF, 1'b0, 32'h0, 1'b1};
        run_vec(v, "both");
        v = '{1'b0, 1'b1, 32'h1000_0004, 32'h0, 4'h0, 1'b1, 32'h55, 1'b1};
        run_vec(v, "both_rd");

        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 32'h1000_0004, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 32'h1000_0008, 32'h0, 4'h0);
        #2;
        reset_n = 1'b0;
        #1;
        idle();
        check("fly_ready", ready, 0);
        check("fly_vld", read_data_valid, 0);
        check("fly_data", read_data, 0);
        check("fly_err", error, 0);
        vs = 0;
        repeat (3) begin
            @(negedge clk);
            if (read_data_valid) vs++;
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("fly_hold_vld", vs, 0);
        wait_init(1'b0, n, vs);
        check("fly_init_len", n, 16);
        check("fly_init_vld", vs, 0);

        do_reset("mid0");
        repeat (5) @(negedge clk);
        check("mid_ready_low", ready, 0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_ready", ready, 0);
        check("mid_rst_cnt", dut.init_cnt, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        wait_init(1'b0, n, vs);
        check("mid_init_len", n, 16);
        check("mid_init_vld", vs, 0);
        v = '{1'b0, 1'b1, 32'h1000_0004, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0};
        run_vec(v, "reinit_rd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_ram_responder.md
BUS_RAM_RESPONDER -- requirements
Module: bus_ram_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12, meaning log2 of the word count of the backing RAM.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h10000000, meaning the byte address of word 0.
REQ-003 SHALL have parameter READ_LATENCY, default 2, legal 1..4, meaning the cycles from read acceptance to read_data_valid.
REQ-004 clk  input  1  the only clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 ready  output  1  high when the responder accepts a request this cycle.
REQ-007 addr  input  32  byte address of the request.
REQ-008 write_data  input  32  write payload.
REQ-009 byte_enable  input  4  per-byte write mask; bit i covers write_data[8i+7:8i].
REQ-010 write_req  input  1  write request.
REQ-011 read_req  input  1  read request.
REQ-012 read_data  output  32  read return data, meaningful only while read_data_valid is high.
REQ-013 read_data_valid  output  1  one-cycle pulse per accepted read.
REQ-014 error  output  1  sticky protocol or decode error flag.

Function
REQ-015 SHALL implement FSM states INIT and ACTIVE; reset SHALL enter INIT.
REQ-016 INIT SHALL hold ready low and write 32'h0 to word k on the k-th cycle, for k = 0 .. 2^ADDR_BITS-1, using a counter of ADDR_BITS+1 bits.
REQ-017 After the write to the last word, the next cycle SHALL be ACTIVE with ready high; ready SHALL stay high in ACTIVE.
REQ-018 Acceptance: a request SHALL be accepted on a rising edge where ready=1 and write_req=1 or read_req=1.
REQ-019 Requests seen while ready=0 SHALL be ignored entirely and SHALL NOT set error.
REQ-020 Decode: a request is in range iff BASE_ADDR <= addr < BASE_ADDR + 4*2^ADDR_BITS.
REQ-021 Decode: word index = (addr - BASE_ADDR)[ADDR_BITS+1:2]; addr[1:0] is ignored.
REQ-022 Accepted in-range write: bytes with byte_enable set SHALL be updated at the acceptance edge; other bytes SHALL be unchanged.
REQ-023 Accepted in-range read: the word as of the acceptance edge SHALL be captured, so a read accepted the cycle after a write to the same word returns the new data.
REQ-024 Read return: an accepted read SHALL produce read_data_valid=1 with its data for exactly the cycle READ_LATENCY cycles after acceptance.
REQ-025 Reads SHALL be fully pipelined: one read accepted per cycle, returned in order, with no ready deassertion.
REQ-026 read_data SHALL be 32'h0 whenever read_data_valid=0.
REQ-027 Out-of-range write SHALL be dropped and SHALL set error.
REQ-028 Out-of-range read SHALL still return a valid pulse with data 32'h0, and SHALL set error.
REQ-029 Simultaneous write_req and read_req on acceptance: the write SHALL be performed, the read discarded (no valid pulse), and error set.
REQ-030 error SHALL remain high until reset.

Reset
REQ-031 Asserting reset_n low, at any time including mid-INIT or with reads in flight, SHALL immediately force: ready=0, read_data_valid=0, read_data=32'h0, error=0, FSM=INIT, init counter=0.
REQ-032 Reset SHALL flush all in-flight reads; no valid pulse from pre-reset requests SHALL appear after reset.

Structure
REQ-033 Bus width constants (address 32, data 32, byte enable 4) and the state enum type (INIT, ACTIVE) SHALL live in shared package bus_pkg.
REQ-034 Storage SHALL be sub-module bus_ram_array: single-port, 2^ADDR_BITS x 32, per-byte write enable, synchronous read.
REQ-035 INIT writes and bus writes SHALL be muxed onto the single port of bus_ram_array.
REQ-036 READ_LATENCY SHALL count from acceptance, including the array's read cycle, to the output.

Verification (ADDR_BITS=4, READ_LATENCY=2)
REQ-037 Release reset -> ready stays low for exactly 16 cycles, then goes high; a read of 0x10000000 returns 0x00000000.
REQ-038 Write 0x10000008 = 0xAABBCCDD with be=4'hF, then write 0x1000000A = 0x11223344 with be=4'b1100, then read 0x10000008 -> 0x1122CCDD, valid exactly 2 cycles after read acceptance.
REQ-039 Back-to-back reads of words 0..3 (after writing 0x0, 0x1, 0x2, 0x3) -> four consecutive valid pulses, data 0x0, 0x1, 0x2, 0x3 in order.
REQ-040 Read 0x20000000 -> valid pulse with data 0x0 and error=1; error remains 1 after 10 further legal cycles.
REQ-041 Both read_req and write_req asserted at 0x10000004 with data 0x55 -> no valid pulse, error=1, and a later read of that address returns 0x55.
REQ-042 Assert reset_n low with 2 reads in flight, and also mid-INIT -> no valid pulse ever appears, and INIT restarts for a full 16 cycles.
